alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
Two-requester round-robin scheduler that time-shares one combinational 16-bit ALU (opcodes 000–111) between independent clients. It latches a granted request's operands and opcode, drives the ALU for one cycle, then captures the result and flags. The response is held until the owning client accepts it. It sits between the instruction-issue logic and the shared ALU.

Parameters:
WIDTH, 16, operand/result width; the ALU is 16-bit, so only 16 is supported.
CNT_W, 16, width of the per-requester completed-operation counters.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_x, req0_y  in  16  requester 0 operands
req0_op  in  3  requester 0 ALU opcode
req0_cin  in  1  requester 0 carry-in (used by op 110)
req1_valid, req1_ready, req1_x, req1_y, req1_op, req1_cin  as above, for requester 1
alu_x, alu_y  out  16  operands to ALU
alu_op  out  3  opcode to ALU
alu_cin  out  1  carry-in to ALU
alu_out  in  16  ALU result
alu_cout, alu_ov, alu_lt, alu_eq, alu_gt  in  1 each  ALU flags
rsp_valid  out  1  result available
rsp_ready  in  1  owner accepts result
rsp_id  out  1  requester that owns the result (0/1)
rsp_data  out  16  captured alu_out
rsp_flags  out  5  captured {cout, ov, lt, eq, gt}
busy  out  1  state != IDLE
done0_cnt, done1_cnt  out  CNT_W  completed (handshaken) responses per requester

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - State IDLE, last_grant=1 (requester 0 wins first tie).
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, busy=0.
  - Counters = 0.
  - Operand/opcode registers = 0, so alu_x/alu_y/alu_op/alu_cin = 0.
- FSM states:
  - IDLE: arbitrate.
    - One valid: grant it.
    - Both valid: grant the requester != last_grant.
    - reqN_ready = 1 combinationally for the granted requester only, only in IDLE.
    - On grant: latch x, y, op, cin and id; set last_grant=id; go to EXEC.
    - No valid: stay in IDLE; both ready=0.
  - EXEC (exactly 1 cycle):
    - alu_* driven from the latched registers. alu_* are registered outputs and hold their value in every state.
    - At the clock edge: rsp_data <= alu_out and rsp_flags <= flags; go to RESP.
  - RESP: rsp_valid=1; rsp_id/rsp_data/rsp_flags stable.
    - rsp_ready=1: increment done{rsp_id}_cnt; go to IDLE; rsp_valid=0 next cycle.
    - rsp_ready=0: hold indefinitely.
- Latency: accept edge N → EXEC in cycle N+1 → rsp_valid in cycle N+2.
  - Minimum 3 cycles per operation (accept, exec, respond). There is no overlap of response and new accept.
- Ready/valid rules:
  - A requester must hold valid and payload until it sees ready.
  - Requests arriving in EXEC/RESP wait and are not accepted.
- Opcodes are passed through unmodified, including 110 (add with cin) and 111 (ALU returns 0).
  - The scheduler performs no opcode checking.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset in EXEC or RESP discards the operation. Counters are not incremented, and all outputs return to reset values the next cycle.
- last_grant updates only on grant, never on response.

Test Plan:
- Single request: req0 x=0x7FFF, y=0x0001, op=000 → rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=0x8000, ov flag=1; done0_cnt=1.
- Simultaneous requests after reset: req0 op=010 x=0xF0F0 y=0xFF00, req1 op=011 x=0x000F y=0x00F0.
  - req0 is served first (data 0xF000), then req1 (data 0x00FF).
  - With both held valid, grants alternate 0,1,0,1.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_data and rsp_id stable. req1_ready=0 throughout; accepted one cycle after rsp_ready=1.
- Reset mid-operation: assert rst in EXEC → next cycle rsp_valid=0, busy=0, counters unchanged. The next request from req1 is still granted correctly.
- Opcode pass-through: op=110 x=0x0001 y=0x0001 cin=1 → alu_cin=1, rsp_data=0x0003. op=111 → rsp_data=0x0000.
- Counter wrap: CNT_W=2, five req1 completions → done1_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_rr_scheduler_if.sv
// rtl/alu_rr_scheduler_if.sv - bundled requester, ALU and response signals for alu_rr_scheduler
//
// Purpose: groups the request handshakes, the shared-ALU bus and the response
// handshake into one bundle.
//   slave  : the scheduler side (accepts requests, drives the ALU, returns results)
//   master : the surroundings (requesters, the combinational ALU, the response sink)
// Signals:
//   req{0,1}_valid/ready/x/y/op/cin : per-requester operation handshake and payload
//   alu_x/alu_y/alu_op/alu_cin      : registered operands to the ALU
//   alu_out/alu_cout/ov/lt/eq/gt    : ALU result and flags
//   rsp_valid/ready/id/data/flags   : held response with owning requester id
interface alu_rr_scheduler_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;
  logic [2:0]       req0_op;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;
  logic [2:0]       req1_op;
  logic             req1_cin;

  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [2:0]       alu_op;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_out;
  logic             alu_cout;
  logic             alu_ov;
  logic             alu_lt;
  logic             alu_eq;
  logic             alu_gt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic [4:0]       rsp_flags;

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_op, req0_cin,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_op, req1_cin,
    output req1_ready,
    output alu_x, alu_y, alu_op, alu_cin,
    input  alu_out, alu_cout, alu_ov, alu_lt, alu_eq, alu_gt,
    output rsp_valid, rsp_id, rsp_data, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_x, req0_y, req0_op, req0_cin,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_op, req1_cin,
    input  req1_ready,
    input  alu_x, alu_y, alu_op, alu_cin,
    output alu_out, alu_cout, alu_ov, alu_lt, alu_eq, alu_gt,
    input  rsp_valid, rsp_id, rsp_data, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - two-requester round-robin scheduler for one shared combinational ALU
//
// Purpose: grants one of two requesters, latches its operation, drives the
// shared ALU for one cycle, captures result and flags, and holds the response
// until the owner accepts it.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   bus        : alu_rr_scheduler_if.slave (requests, ALU bus, response)
//   busy       : high whenever an operation is in flight (not IDLE)
//   done0_cnt  : completed responses for requester 0 (wraps)
//   done1_cnt  : completed responses for requester 1 (wraps)
module alu_rr_scheduler #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_rr_scheduler_if.slave bus,
  output logic              busy,
  output logic [CNT_W-1:0]  done0_cnt,
  output logic [CNT_W-1:0]  done1_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [2:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [4:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic any_valid;
  logic grant_id;

  // On a tie the requester that did not win last time is chosen; otherwise
  // the only valid requester wins (grant_id is don't-care when none is valid).
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = bus.req1_valid;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    x_d            = x_q;
    y_d            = y_q;
    op_d           = op_q;
    cin_d          = cin_q;
    id_d           = id_q;
    data_d         = data_q;
    flags_d        = flags_q;
    cnt0_d         = cnt0_q;
    cnt1_d         = cnt1_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          x_d            = grant_id ? bus.req1_x   : bus.req0_x;
          y_d            = grant_id ? bus.req1_y   : bus.req0_y;
          op_d           = grant_id ? bus.req1_op  : bus.req0_op;
          cin_d          = grant_id ? bus.req1_cin : bus.req0_cin;
          id_d           = grant_id;
          last_grant_d   = grant_id;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        // The ALU has seen the latched operands for this whole cycle.
        data_d  = bus.alu_out;
        flags_d = {bus.alu_cout, bus.alu_ov, bus.alu_lt, bus.alu_eq, bus.alu_gt};
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          if (id_q) begin
            cnt1_d = cnt1_q + CNT_ONE;
          end else begin
            cnt0_d = cnt0_q + CNT_ONE;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      x_q          <= '0;
      y_q          <= '0;
      op_q         <= '0;
      cin_q        <= 1'b0;
      id_q         <= 1'b0;
      data_q       <= '0;
      flags_q      <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      op_q         <= op_d;
      cin_q        <= cin_d;
      id_q         <= id_d;
      data_q       <= data_d;
      flags_q      <= flags_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign bus.alu_x     = x_q;
  assign bus.alu_y     = y_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_cin   = cin_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;
  assign busy          = (state_q != IDLE);
  assign done0_cnt     = cnt0_q;
  assign done1_cnt     = cnt1_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - self-checking bench for alu_rr_scheduler
module tb_alu_rr_scheduler;

  localparam int TB_CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic [TB_CNT_W-1:0] done0_cnt, done1_cnt;

  always #5 clk = ~clk;

  alu_rr_scheduler_if bus ();

  alu_rr_scheduler #(.WIDTH(16), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .done0_cnt (done0_cnt),
    .done1_cnt (done1_cnt)
  );

  // Reference ALU: {out[15:0], cout, ov, lt, eq, gt}; comparisons are unsigned x vs y.
  function automatic logic [20:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                         input logic [2:0] op, input logic cin);
    logic [16:0] s;
    logic v;
    s = 17'h0;
    v = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, x} + {1'b0, y};
        v = (x[15] == y[15]) && (s[15] != x[15]);
      end
      3'b001: begin
        s = {1'b0, x} + {1'b0, ~y} + 17'd1;
        v = (x[15] != y[15]) && (s[15] != x[15]);
      end
      3'b010: s = {1'b0, x & y};
      3'b011: s = {1'b0, x | y};
      3'b100: s = {1'b0, x ^ y};
      3'b101: s = {1'b0, ~x};
      3'b110: begin
        s = {1'b0, x} + {1'b0, y} + {16'h0, cin};
        v = (x[15] == y[15]) && (s[15] != x[15]);
      end
      default: s = 17'h0;
    endcase
    return {s[15:0], s[16], v, x < y, x == y, x > y};
  endfunction

  always_comb begin
    {bus.alu_out, bus.alu_cout, bus.alu_ov, bus.alu_lt, bus.alu_eq, bus.alu_gt} =
      alu_fn(bus.alu_x, bus.alu_y, bus.alu_op, bus.alu_cin);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: at most one operation in flight; a response is
  // due two cycles after its accept and stays until rsp_ready; ties go to the
  // requester that did not win last time.
  bit          m_init = 0;
  bit          inflight;
  int          acc_cyc;
  int          cyc = 0;
  bit          last;
  bit          exp_id;
  logic [15:0] exp_data, ex_x, ex_y;
  logic [4:0]  exp_flags;
  logic [2:0]  ex_op;
  logic        ex_cin;
  int          cnt0, cnt1;

  // Values sampled in the latest cycle (what the next edge acts on).
  logic        s_r0, s_r1, s_rv, s_id;
  logic [15:0] s_data;
  logic [4:0]  s_flags;

  task automatic model_step();
    bit v0, v1, winner, e_rv;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    winner = (v0 && v1) ? ~last : v1;
    e_rv = inflight && (cyc >= acc_cyc + 2);
    if (m_init) begin
      check("req0_ready", s_r0, !inflight && v0 && !winner);
      check("req1_ready", s_r1, !inflight && v1 && winner);
      check("busy", busy, inflight);
      check("rsp_valid", s_rv, e_rv);
      if (e_rv) begin
        check("rsp_id", s_id, exp_id);
        check("rsp_data", s_data, exp_data);
        check("rsp_flags", s_flags, exp_flags);
      end
      if (inflight && cyc == acc_cyc + 1) begin
        check("alu_x", bus.alu_x, ex_x);
        check("alu_y", bus.alu_y, ex_y);
        check("alu_op", bus.alu_op, ex_op);
        check("alu_cin", bus.alu_cin, ex_cin);
      end
      check("done0_cnt", done0_cnt, cnt0 & 3);
      check("done1_cnt", done1_cnt, cnt1 & 3);
    end
    if (rst) begin
      m_init = 1;
      inflight = 0;
      last = 1;
      cnt0 = 0;
      cnt1 = 0;
    end else if (m_init) begin
      if (e_rv && bus.rsp_ready) begin
        inflight = 0;
        if (exp_id) cnt1++; else cnt0++;
      end else if (!inflight && (v0 || v1)) begin
        inflight = 1;
        acc_cyc = cyc;
        exp_id = winner;
        last = winner;
        ex_x   = winner ? bus.req1_x   : bus.req0_x;
        ex_y   = winner ? bus.req1_y   : bus.req0_y;
        ex_op  = winner ? bus.req1_op  : bus.req0_op;
        ex_cin = winner ? bus.req1_cin : bus.req0_cin;
        {exp_data, exp_flags} = alu_fn(ex_x, ex_y, ex_op, ex_cin);
      end
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    #1;
    s_r0    = bus.req0_ready;
    s_r1    = bus.req1_ready;
    s_rv    = bus.rsp_valid;
    s_id    = bus.rsp_id;
    s_data  = bus.rsp_data;
    s_flags = bus.rsp_flags;
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_req(input bit id, input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic [2:0] op, input logic cin);
    if (id) begin
      bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y; bus.req1_op = op; bus.req1_cin = cin;
    end else begin
      bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y; bus.req0_op = op; bus.req0_cin = cin;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_op(input bit id, input logic [15:0] x, input logic [15:0] y,
                        input logic [2:0] op, input logic cin,
                        output logic [15:0] d, output logic [4:0] f, output logic rid);
    bit got;
    set_req(id, 1'b1, x, y, op, cin);
    bus.rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (id ? s_r1 : s_r0) got = 1;
    end
    check("accept_timeout", got, 1);
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    got = 0;
    d = '0;
    f = '0;
    rid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (s_rv) begin
        got = 1; d = s_data; f = s_flags; rid = s_id;
      end
    end
    check("rsp_timeout", got, 1);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [2:0]  op;
    logic        cin;
    logic [15:0] data;
    logic [4:0]  flags;
  } vec_t;

  initial begin
    vec_t vecs[8];
    logic [15:0] d;
    logic [4:0] f;
    logic rid;
    int grants[$];
    logic [15:0] rdata[$];
    logic [15:0] held_data;
    bit got;
    logic [3:0] wrap_exp[5];

    vecs[0] = '{16'h7FFF, 16'h0001, 3'b000, 1'b0, 16'h8000, 5'b01001};
    vecs[1] = '{16'hF0F0, 16'hFF00, 3'b010, 1'b0, 16'hF000, 5'b00100};
    vecs[2] = '{16'h000F, 16'h00F0, 3'b011, 1'b0, 16'h00FF, 5'b00100};
    vecs[3] = '{16'h0001, 16'h0001, 3'b110, 1'b1, 16'h0003, 5'b00010};
    vecs[4] = '{16'h1234, 16'h1234, 3'b111, 1'b0, 16'h0000, 5'b00010};
    vecs[5] = '{16'hFFFF, 16'h0001, 3'b000, 1'b0, 16'h0000, 5'b10001};
    vecs[6] = '{16'h0000, 16'h0001, 3'b001, 1'b0, 16'hFFFF, 5'b00100};
    vecs[7] = '{16'hAAAA, 16'h5555, 3'b100, 1'b0, 16'hFFFF, 5'b00001};
    wrap_exp = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};

    rst = 1'b1;
    set_req(0, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state.
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_flags", bus.rsp_flags, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_x", bus.alu_x, 0);
    check("rst_alu_y", bus.alu_y, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_alu_cin", bus.alu_cin, 0);
    check("rst_cnt0", done0_cnt, 0);
    check("rst_cnt1", done1_cnt, 0);
    check("rst_ready0", bus.req0_ready, 0);
    @(negedge clk);

    // Table of single operations, alternating requesters.
    for (int i = 0; i < 8; i++) begin
      run_op(i[0], vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].cin, d, f, rid);
      check($sformatf("vec%0d_data", i), d, vecs[i].data);
      check($sformatf("vec%0d_flags", i), f, vecs[i].flags);
      check($sformatf("vec%0d_id", i), rid, i[0]);
      if (i == 0) check("vec0_done0", done0_cnt, 1);
    end

    // Simultaneous requests held valid: grants 0,1,0,1 with matching data.
    do_reset();
    set_req(0, 1'b1, 16'hF0F0, 16'hFF00, 3'b010, 1'b0);
    set_req(1, 1'b1, 16'h000F, 16'h00F0, 3'b011, 1'b0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      cycle();
      if (s_r0) grants.push_back(0);
      if (s_r1) grants.push_back(1);
      if (s_rv) rdata.push_back(s_data);
    end
    check("rr_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) check($sformatf("rr_grant%0d", i), grants[i], i % 2);
    check("rr_rsp_count_ge2", rdata.size() >= 2, 1);
    if (rdata.size() >= 2) begin
      check("rr_data0", rdata[0], 16'hF000);
      check("rr_data1", rdata[1], 16'h00FF);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Backpressure: response held 10 cycles, req1 waits, then accepted next cycle.
    do_reset();
    set_req(0, 1'b1, 16'h1111, 16'h2222, 3'b000, 1'b0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (s_r0) got = 1;
    end
    check("bp_accept", got, 1);
    bus.req0_valid = 1'b0;
    set_req(1, 1'b1, 16'h0005, 16'h0003, 3'b001, 1'b0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (s_rv) got = 1;
    end
    check("bp_rsp", got, 1);
    held_data = s_data;
    check("bp_held_data", held_data, 16'h3333);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_valid_hold", s_rv, 1);
      check("bp_data_hold", s_data, held_data);
      check("bp_id_hold", s_id, 0);
      check("bp_req1_wait", s_r1, 0);
    end
    bus.rsp_ready = 1'b1;
    cycle();
    cycle();
    check("bp_req1_accept", s_r1, 1);
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Reset while in EXEC discards the operation.
    set_req(0, 1'b1, 16'h0101, 16'h0202, 3'b000, 1'b0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (s_r0) got = 1;
    end
    check("mid_accept", got, 1);
    bus.req0_valid = 1'b0;
    check("mid_in_exec", busy, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("mid_rsp_valid", bus.rsp_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_cnt0", done0_cnt, 0);
    check("mid_cnt1", done1_cnt, 0);
    @(negedge clk);
    cycle();
    run_op(1, 16'h0040, 16'h0002, 3'b000, 1'b0, d, f, rid);
    check("mid_after_id", rid, 1);
    check("mid_after_data", d, 16'h0042);

    // Counter wrap with a 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(1, 16'(i), 16'h0001, 3'b000, 1'b0, d, f, rid);
      check($sformatf("wrap_cnt%0d", i), done1_cnt, wrap_exp[i]);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 149) == 0);
      cycle();
      if (!bus.req0_valid || (s_r0 && !rst))
        set_req(0, $urandom_range(0, 2) != 0, 16'($urandom), 16'($urandom),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (!bus.req1_valid || (s_r1 && !rst))
        set_req(1, $urandom_range(0, 2) != 0, 16'($urandom), 16'($urandom),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
